ctc_irq_ctrl: RTL



---
 rtl/ctc_irq_pkg.sv | 21 ++
 rtl/ctc_irq_pend.sv | 31 +++
 rtl/ctc_irq_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ctc_irq_pkg.sv
// Shared types and constants for the CTC interrupt/access controller.
package ctc_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RD  = 2'd1,
    ST_ACK_RD  = 2'd2,
    ST_ACK_CAP = 2'd3
  } state_t;

  localparam logic [2:0] STAT0 = 3'b000;
  localparam logic [2:0] STAT1 = 3'b010;
  localparam logic [2:0] CNT0  = 3'b100;
  localparam logic [2:0] CNT1  = 3'b110;

  // Status register offset for the channel being acknowledged.
  function automatic logic [2:0] stat_addr(input logic id);
    return id ? STAT1 : STAT0;
  endfunction

endpackage

// File: rtl/ctc_irq_pend.sv
// Per-channel falling-edge detector on an active-low timer output, plus a
// pending flop in which a new event takes precedence over a same-cycle clear.
module ctc_irq_pend
  import ctc_irq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic ctc_n,
  input  logic clear,
  output logic pend
);

  logic prev_reg;
  logic fall;

  assign fall = prev_reg & ~ctc_n;

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_reg <= 1'b1;
      pend     <= 1'b0;
    end else begin
      prev_reg <= ctc_n;
      if (fall)
        pend <= 1'b1;
      else if (clear)
        pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ctc_irq_ctrl.sv
// Interrupt controller and register-port arbiter for a two-channel timer:
// CPU accesses take priority; acknowledges do a status read that clears the timer.
module ctc_irq_ctrl
  import ctc_irq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read_enable,
  input  logic        cpu_write_enable,
  input  logic        cpu_ctc_sel,
  input  logic [2:0]  cpu_address,
  input  logic [15:0] cpu_write_data,
  output logic [15:0] cpu_read_data,
  output logic        cpu_ready,
  output logic        tmr_read_enable,
  output logic        tmr_write_enable,
  output logic        tmr_ctrl,
  output logic [2:0]  tmr_address,
  output logic [15:0] tmr_write_data,
  input  logic [15:0] tmr_read_data,
  input  logic        ctc0_n,
  input  logic        ctc1_n,
  input  logic [1:0]  irq_enable,
  output logic        intr,
  output logic        intr_id,
  input  logic        intr_ack,
  output logic        ack_done,
  output logic [15:0] intr_status
);

  state_t      state_reg, state_next;
  logic        ack_id_reg;
  logic        ack_start;
  logic [1:0]  ctc_n;
  logic [1:0]  pend;
  logic [1:0]  clear;
  logic [1:0]  masked;
  logic        cpu_req;

  assign ctc_n = {ctc1_n, ctc0_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      ctc_irq_pend u_pend (
        .clock (clock),
        .reset (reset),
        .ctc_n (ctc_n[gi]),
        .clear (clear[gi]),
        .pend  (pend[gi])
      );
    end
  endgenerate

  assign masked  = pend & irq_enable;
  assign intr    = reset & (|masked);
  assign intr_id = reset & ~masked[0] & masked[1];
  assign cpu_req = cpu_ctc_sel & (cpu_read_enable | cpu_write_enable);
  assign clear   = ack_done ? (ack_id_reg ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_next       = state_reg;
    ack_start        = 1'b0;
    cpu_ready        = 1'b0;
    cpu_read_data    = '0;
    tmr_read_enable  = 1'b0;
    tmr_write_enable = 1'b0;
    tmr_ctrl         = 1'b0;
    tmr_address      = '0;
    tmr_write_data   = '0;
    ack_done         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_req) begin
          tmr_ctrl       = 1'b1;
          tmr_address    = cpu_address;
          tmr_write_data = cpu_write_data;
          if (cpu_write_enable) begin
            tmr_write_enable = 1'b1;
            cpu_ready        = 1'b1;
          end else begin
            tmr_read_enable = 1'b1;
            state_next      = ST_CPU_RD;
          end
        end else if (intr_ack && intr) begin
          ack_start  = 1'b1;
          state_next = ST_ACK_RD;
        end
      end
      ST_CPU_RD: begin
        cpu_ready     = 1'b1;
        cpu_read_data = tmr_read_data;
        state_next    = ST_IDLE;
      end
      ST_ACK_RD: begin
        tmr_read_enable = 1'b1;
        tmr_ctrl        = 1'b1;
        tmr_address     = stat_addr(ack_id_reg);
        state_next      = ST_ACK_CAP;
      end
      ST_ACK_CAP: begin
        ack_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset forces every output low, including the combinational CPU pass-through.
    if (!reset) begin
      state_next       = ST_IDLE;
      ack_start        = 1'b0;
      cpu_ready        = 1'b0;
      cpu_read_data    = '0;
      tmr_read_enable  = 1'b0;
      tmr_write_enable = 1'b0;
      tmr_ctrl         = 1'b0;
      tmr_address      = '0;
      tmr_write_data   = '0;
      ack_done         = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      ack_id_reg  <= 1'b0;
      intr_status <= '0;
    end else begin
      state_reg <= state_next;
      if (ack_start)
        ack_id_reg <= intr_id;
      if (state_reg == ST_ACK_CAP)
        intr_status <= tmr_read_data;
    end
  end

endmodule
